// File: rtl/ser_pkg.sv
// Shared types for the serial-stream stages: the serializer FSM and the
// sequence-detector state encodings that consume its output.
package ser_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } ser_state_t;

    typedef enum logic [1:0] {
        DET_S0,
        DET_S1,
        DET_S2,
        DET_S3
    } det_mealy_state_t;

    typedef enum logic [2:0] {
        DET_M0,
        DET_M1,
        DET_M2,
        DET_M3,
        DET_M4
    } det_moore_state_t;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage with one holding word so consecutive words
// leave back to back; drives a fixed idle level between words.
module piso_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT_CNT = CW'(WIDTH - 2);

    ser_state_t       state_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic [WIDTH-1:0] hbuf_reg;
    logic             hbuf_full_reg;
    logic [CW-1:0]    cnt_reg;
    logic             x_reg;
    logic             x_valid_reg;
    logic             word_done_reg;

    logic             accept;
    logic [WIDTH-1:0] load_src;
    logic [WIDTH-1:0] load_ord;

    assign in_ready = !reset && !hbuf_full_reg;
    assign accept   = in_valid && in_ready;
    assign load_src = hbuf_full_reg ? hbuf_reg : in_data;

    // Reorder the incoming word into transmit order so the shifter always
    // emits bit 0 and shifts right, whichever end leaves first.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_order
            if (MSB_FIRST) begin : g_msb
                assign load_ord[gi] = load_src[WIDTH-1-gi];
            end else begin : g_lsb
                assign load_ord[gi] = load_src[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            shreg_reg     <= '0;
            hbuf_reg      <= '0;
            hbuf_full_reg <= 1'b0;
            cnt_reg       <= '0;
            x_reg         <= IDLE_BIT;
            x_valid_reg   <= 1'b0;
            word_done_reg <= 1'b0;
        end else begin
            word_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        x_reg       <= load_ord[0];
                        shreg_reg   <= load_ord >> 1;
                        x_valid_reg <= 1'b1;
                        cnt_reg     <= '0;
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_reg != LAST_CNT) begin
                        x_reg         <= shreg_reg[0];
                        shreg_reg     <= shreg_reg >> 1;
                        cnt_reg       <= cnt_reg + CW'(1);
                        word_done_reg <= (cnt_reg == PENULT_CNT);
                        if (accept) begin
                            hbuf_reg      <= in_data;
                            hbuf_full_reg <= 1'b1;
                        end
                    end else if (hbuf_full_reg || accept) begin
                        // Last bit is on x: next word follows with no gap.
                        x_reg         <= load_ord[0];
                        shreg_reg     <= load_ord >> 1;
                        hbuf_full_reg <= 1'b0;
                        cnt_reg       <= '0;
                    end else begin
                        x_reg       <= IDLE_BIT;
                        x_valid_reg <= 1'b0;
                        cnt_reg     <= '0;
                        state_reg   <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign x         = x_reg;
    assign x_valid   = x_valid_reg;
    assign word_done = word_done_reg;
    assign busy      = (state_reg == SHIFT) || hbuf_full_reg;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first, LSB-first and idle-high
// instances share one stimulus stream.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;

    logic m_ready, m_x, m_xv, m_wd, m_busy;
    logic l_ready, l_x, l_xv, l_wd, l_busy;
    logic i_ready, i_x, i_xv, i_wd, i_busy;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(m_ready), .x(m_x), .x_valid(m_xv), .word_done(m_wd), .busy(m_busy)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(l_ready), .x(l_x), .x_valid(l_xv), .word_done(l_wd), .busy(l_busy)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_i (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(i_ready), .x(i_x), .x_valid(i_xv), .word_done(i_wd), .busy(i_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]  bits4;
        logic [7:0]  seq8;
        logic [11:0] seq12;
        logic [13:0] rdy14;
        logic [3:0]  words [3];
        int          idx;
        logic        acc;

        words[0] = 4'h1;
        words[1] = 4'h2;
        words[2] = 4'h3;

        // Reset state
        tick();
        tick();
        check("rst_ready", m_ready, 0);
        check("rst_x", m_x, 0);
        check("rst_xv", m_xv, 0);
        check("rst_wd", m_wd, 0);
        check("rst_busy", m_busy, 0);
        check("rst_idle1_x", i_x, 1);
        reset = 1'b0;
        #1;
        check("ready_after_rst", m_ready, 1);

        // Single word 1011, MSB first
        in_valid = 1'b1;
        in_data  = 4'b1011;
        tick();
        in_valid = 1'b0;
        bits4 = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("w1_x%0d", i), m_x, bits4[3-i]);
            check($sformatf("w1_xv%0d", i), m_xv, 1);
            check($sformatf("w1_wd%0d", i), m_wd, (i == 3) ? 1 : 0);
            check($sformatf("w1_idle1_x%0d", i), i_x, bits4[3-i]);
            tick();
        end
        check("w1_after_x", m_x, 0);
        check("w1_after_xv", m_xv, 0);
        check("w1_after_wd", m_wd, 0);
        check("w1_after_busy", m_busy, 0);
        check("w1_after_idle1_x", i_x, 1);
        check("w1_after_idle1_xv", i_xv, 0);
        $display("[TB] single word 1011 serialized");

        // Back-to-back B then A
        tick();
        in_valid = 1'b1;
        in_data  = 4'hB;
        tick();
        in_data = 4'hA;
        seq8 = 8'b1011_1010;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) in_valid = 1'b0;
            check($sformatf("b2b_x%0d", i), m_x, seq8[7-i]);
            check($sformatf("b2b_xv%0d", i), m_xv, 1);
            check($sformatf("b2b_wd%0d", i), m_wd, (i == 3 || i == 7) ? 1 : 0);
            check($sformatf("b2b_rdy%0d", i), m_ready, (i >= 1 && i <= 3) ? 0 : 1);
            check($sformatf("b2b_busy%0d", i), m_busy, 1);
            tick();
        end
        check("b2b_after_xv", m_xv, 0);
        check("b2b_after_idle1_x", i_x, 1);
        $display("[TB] back-to-back B,A serialized");

        // Backpressure: 1,2,3 offered continuously
        seq12 = 12'b0001_0010_0011;
        rdy14 = 14'b11_1110_0010_0011;   // bit k = expected in_ready at step k
        idx = 0;
        for (int k = 0; k < 14; k++) begin
            in_valid = (idx < 3);
            in_data  = (idx < 3) ? words[idx] : 4'h0;
            check($sformatf("bp_rdy%0d", k), m_ready, rdy14[k]);
            if (k >= 1 && k <= 12) begin
                check($sformatf("bp_x%0d", k), m_x, seq12[12-k]);
                check($sformatf("bp_xv%0d", k), m_xv, 1);
                check($sformatf("bp_wd%0d", k), m_wd, (k % 4 == 0) ? 1 : 0);
            end
            if (k == 13) begin
                check("bp_after_xv", m_xv, 0);
                check("bp_after_x", m_x, 0);
            end
            acc = in_valid && m_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("bp_words_accepted", idx, 3);
        $display("[TB] backpressure 1,2,3 serialized");

        // LSB-first word 1101
        in_valid = 1'b1;
        in_data  = 4'b1101;
        tick();
        in_valid = 1'b0;
        bits4 = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("lsb_x%0d", i), l_x, bits4[i]);
            check($sformatf("lsb_xv%0d", i), l_xv, 1);
            check($sformatf("lsb_wd%0d", i), l_wd, (i == 3) ? 1 : 0);
            check($sformatf("lsb_msbref_x%0d", i), m_x, bits4[3-i]);
            tick();
        end
        check("lsb_after_xv", l_xv, 0);
        check("lsb_after_busy", l_busy, 0);
        $display("[TB] LSB-first word 1101 serialized");

        // Reset mid-word with hbuf full
        tick();
        in_valid = 1'b1;
        in_data  = 4'hF;
        tick();
        in_data = 4'h5;
        check("rmw_bit0", m_x, 1);
        tick();
        in_valid = 1'b0;
        check("rmw_bit1", m_x, 1);
        check("rmw_hbuf_rdy", m_ready, 0);
        check("rmw_busy", m_busy, 1);
        reset = 1'b1;
        tick();
        check("rmw_rst_ready", m_ready, 0);
        check("rmw_x", m_x, 0);
        check("rmw_xv", m_xv, 0);
        check("rmw_busy_clr", m_busy, 0);
        check("rmw_wd", m_wd, 0);
        check("rmw_idle1_x", i_x, 1);
        reset = 1'b0;
        #1;
        check("rmw_ready_after", m_ready, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rmw_quiet_xv%0d", i), m_xv, 0);
            check($sformatf("rmw_quiet_wd%0d", i), m_wd, 0);
        end
        in_valid = 1'b1;
        in_data  = 4'h6;
        tick();
        in_valid = 1'b0;
        in_data  = 4'hF;
        bits4 = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rmw_new_x%0d", i), m_x, bits4[3-i]);
            check($sformatf("rmw_new_xv%0d", i), m_xv, 1);
            check($sformatf("rmw_new_wd%0d", i), m_wd, (i == 3) ? 1 : 0);
            tick();
        end
        check("rmw_new_after_xv", m_xv, 0);
        check("rmw_new_after_idle1_x", i_x, 1);
        $display("[TB] reset mid-word, then word 6 serialized");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out stage that turns handshaked WIDTH-bit words into the one-bit-per-clock stream consumed by the sequence detectors (their `x` input). It double-buffers one word so consecutive words leave with no gap bits. Between words it drives a fixed idle level. Detectors sample `x` every clock, so idle bits are part of the stream they see.

## Interface
- WIDTH, 8: word width, ≥2
- MSB_FIRST, 1: 1 = bit WIDTH-1 leaves first; 0 = bit 0 first
- IDLE_BIT, 0: value driven on `x` when no word is shifting
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high; one clock, one synchronous active-high reset, no other clock or async path
- in_valid  in  1  producer offers `in_data`
- in_data  in  WIDTH  word to serialize
- in_ready  out  1  stage can take a word; transfer on posedge where in_valid && in_ready
- x  out  1  serial bit (registered)
- x_valid  out  1  `x` carries a data bit this cycle (registered)
- word_done  out  1  one-cycle pulse, high in the cycle the last bit of a word is on `x`
- busy  out  1  shifter active or holding buffer full

## Operation
- Storage: shift register `shreg`, bit counter `cnt` (0..WIDTH-1), holding register `hbuf` + `hbuf_full`.
- FSM (`ser_state_t`): IDLE, SHIFT.
  - IDLE: `x`=IDLE_BIT, `x_valid`=0. On an accepted word, load `shreg`, `cnt`=0, go to SHIFT.
  - SHIFT: one bit per clock; `cnt` increments each cycle.
  - When `cnt`==WIDTH-1 (last bit on `x`) and `hbuf_full`: load `hbuf` into `shreg`, clear `hbuf_full`, stay in SHIFT, `cnt`=0.
  - When `cnt`==WIDTH-1 and a word is accepted this same edge: that word goes straight to `shreg`.
  - When `cnt`==WIDTH-1 and no word is pending: go to IDLE.
- Accept routing: an accepted word goes to `shreg` if the shifter is free at that edge (IDLE, or the last bit is on `x` with `hbuf` empty). Otherwise it goes to `hbuf`.
- in_ready = !reset && !hbuf_full (combinational from the register). Never depends on in_valid.
- Bit order: MSB_FIRST=1 sends in_data[WIDTH-1] down to [0]. MSB_FIRST=0 sends [0] up to [WIDTH-1].
- busy = (state==SHIFT) || hbuf_full.
- Reset values:
  - state=IDLE, `x`=IDLE_BIT, `x_valid`=0, `word_done`=0.
  - `hbuf_full`=0, `cnt`=0.
  - in_ready=0 while reset is high, 1 on the first cycle after.
- Reset mid-word: the partial word and any `hbuf` contents are discarded. No further data bits appear, and no `word_done` is emitted for the dropped word.
- `in_data` is sampled only at the transfer edge. Later changes to `in_data` have no effect.

## Timing
- Latency: word accepted at edge E → first bit on `x` in the cycle after E → last bit WIDTH cycles after E, with `word_done` high in that same cycle.
- Throughput: one word per WIDTH cycles sustained, zero idle bits between words, provided the next word is accepted no later than the edge ending its predecessor's last-bit cycle.
- in_ready is low only while `hbuf_full`. It returns high the cycle after `hbuf` moves into `shreg`.
- Simultaneous accept + last-bit with `hbuf` full cannot occur, because in_ready is low in that case.
- `x` and `x_valid` are flop outputs, with no combinational path from inputs.

## Structure
- Shared package `ser_pkg`: `ser_state_t` enum {IDLE, SHIFT}. The same package holds the detector state enums so that stream-side stages share one source.
- Counter width: $clog2(WIDTH), derived locally.
- Flat module: the holding register is ~15 lines, and a sub-module is not warranted.

## Test plan
- WIDTH=4, MSB_FIRST=1, accept 4'b1011 at edge E, no further input:
  - `x` = 1,0,1,1 in cycles E+1..E+4, `x_valid`=1 in those cycles, `word_done` high only at E+4.
  - `x`=0 and `x_valid`=0 from E+5.
  - A chained Moore detector raises z in cycle E+5.
- Back-to-back: offer 4'hB then 4'hA with in_valid held:
  - 8 contiguous valid bits 1,0,1,1,1,0,1,0.
  - `word_done` at bits 4 and 8, no idle bit between the words.
- Backpressure: offer 4'h1, 4'h2, 4'h3 continuously:
  - in_ready drops after the second word is accepted and rises the cycle after the second word is loaded into the shifter.
  - Serial output is exactly 0001 0010 0011 with no gaps, and no word is lost or duplicated.
- LSB-first: MSB_FIRST=0, word 4'b1101 → `x` = 1,0,1,1.
- Reset mid-word: assert reset during the second bit of 4'hF with `hbuf` holding 4'h5:
  - next cycle `x`=IDLE_BIT, `x_valid`=0, busy=0, and no `word_done`.
  - A new word after reset serializes normally.
- IDLE_BIT=1: idle `x`=1 both after reset and between separated words.
